// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: PC/instruction
// widths, fetch FSM state encoding and the sequential next-PC helper.
package fetch_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [1:0]         state_t;

  // Fetch FSM encoding (plain constants so legacy tools can read them)
  localparam logic [1:0] FETCH = 2'd0;  // address held, wait counter running
  localparam logic [1:0] VALID = 2'd1;  // instruction presented to decode
  localparam logic [1:0] HALT  = 2'd2;  // stopped on a misaligned redirect

  // Sequential fetch: PC + 4, wrapping modulo 2^64
  function automatic pc_t next_seq_pc(input pc_t pc);
    return pc + pc_t'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, the next-PC logic
// and decode. The master modport is the fetch unit's view.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  pc_t    InstrAddr;   // address to instruction memory
  instr_t InstrData;   // word returned by memory
  instr_t Instr;       // latched instruction to decode
  pc_t    InstrPC;     // PC of Instr
  logic   InstrValid;  // Instr/InstrPC valid
  logic   InstrReady;  // decode accepts
  logic   Redirect;    // branch taken
  pc_t    RedirectPC;  // branch target
  logic   AlignErr;    // sticky misaligned-redirect flag

  modport master (
    output InstrAddr, Instr, InstrPC, InstrValid, AlignErr,
    input  InstrData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  InstrAddr, Instr, InstrPC, InstrValid, AlignErr,
    output InstrData, InstrReady, Redirect, RedirectPC
  );

endinterface

// File: rtl/fetch_wait_counter.sv
// Memory-settle wait counter for the fetch stage. Counts while enabled and
// flags the terminal count RD_CYCLES-1, the cycle on which read data is taken.
module fetch_wait_counter #(
  parameter int RD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [3:0] count;

  assign terminal = (count == 4'(RD_CYCLES - 1));

  // Clear wins over counting so a redirect or latch restarts the wait at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= 4'd0;
    else if (clear)  count <= 4'd0;
    else if (enable) count <= count + 4'd1;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the 64-bit PC, holds the memory address for
// RD_CYCLES cycles, latches the returned word and offers it to decode via
// InstrValid/InstrReady. Redirects override sequential fetch.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect halts
// fetch and raises AlignErr; otherwise the low PC bits are cleared on load).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          RD_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  state_t state, state_next;
  pc_t    pc, pc_next;
  instr_t instr;
  pc_t    instr_pc;
  logic   align_err;

  logic   terminal;
  logic   redirect_go;
  logic   misaligned;
  logic   latch;
  pc_t    redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  // HALT ignores redirects; a misaligned target is loaded as-is and halts
  assign redirect_go = bus.Redirect && (state != HALT);
  assign misaligned  = |bus.RedirectPC[1:0];
  assign redirect_pc = bus.RedirectPC;
`else
  // Without the check, targets are silently word-aligned
  assign redirect_go = bus.Redirect;
  assign misaligned  = 1'b0;
  assign redirect_pc = bus.RedirectPC & ~pc_t'(3);
`endif

  // Data is taken only on the last wait cycle of an undisturbed fetch
  assign latch = (state == FETCH) && terminal && !redirect_go;

  fetch_wait_counter #(.RD_CYCLES(RD_CYCLES)) u_wait (
    .clk      (CLK),
    .rst      (Reset),
    .clear    (redirect_go || latch),
    .enable   (state == FETCH),
    .terminal (terminal)
  );

  // Next state / next PC: redirect first, then the normal fetch sequence
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_go) begin
      pc_next    = redirect_pc;
      state_next = misaligned ? HALT : FETCH;
    end else begin
      case (state)
        FETCH: if (terminal) state_next = VALID;
        VALID: if (bus.InstrReady) begin
          pc_next    = next_seq_pc(pc);
          state_next = FETCH;
        end
        HALT:    state_next = HALT;
        default: state_next = FETCH;
      endcase
    end
  end

  // FSM and PC registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Output registers: capture the memory word and its PC on the latch cycle
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      instr    <= '0;
      instr_pc <= RESET_PC;
    end else if (latch) begin
      instr    <= bus.InstrData;
      instr_pc <= pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky error flag, cleared only by reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                         align_err <= 1'b0;
    else if (redirect_go && misaligned) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif

  assign bus.InstrAddr  = pc;
  assign bus.Instr      = instr;
  assign bus.InstrPC    = instr_pc;
  assign bus.InstrValid = (state == VALID);
  assign bus.AlignErr   = align_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit (RD_CYCLES = 2,
// RESET_PC = 0). Memory is modelled as a combinational lookup on InstrAddr.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (64'h0),
    .RD_CYCLES (2)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h4:   return 32'hF84083EA;
      64'h1C:  return 32'hB5000123;
      default: return {4'hD, a[27:0]};
    endcase
  endfunction

  always_comb bus.InstrData = mem_word(bus.InstrAddr);

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        ready;
    logic        valid;
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic redir, input logic [63:0] rpc, input logic ready,
                     input logic valid, input logic [63:0] addr, input logic [31:0] instr,
                     input logic [63:0] pc, input logic err);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ready = ready; v.valid = valid;
    v.addr = addr; v.instr = instr; v.pc = pc; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic valid, input logic [63:0] addr,
                             input logic [31:0] instr, input logic [63:0] pc, input logic err);
    chk({tag, " InstrValid"}, 64'(bus.InstrValid), 64'(valid));
    chk({tag, " InstrAddr"},  bus.InstrAddr, addr);
    chk({tag, " Instr"},      64'(bus.Instr), 64'(instr));
    chk({tag, " InstrPC"},    bus.InstrPC, pc);
    chk({tag, " AlignErr"},   64'(bus.AlignErr), 64'(err));
  endtask

  int cyc;

  initial begin
    // redir rpc ready | valid addr instr pc err   (outputs after the edge)
    add(0, 64'h0, 1,  0, 64'h0,  32'h0,        64'h0,  0);   // 0 wait
    add(0, 64'h0, 1,  1, 64'h0,  32'hF84003E9, 64'h0,  0);   // 1 first valid
    add(0, 64'h0, 1,  0, 64'h4,  32'hF84003E9, 64'h0,  0);   // 2 accepted
    add(0, 64'h0, 0,  0, 64'h4,  32'hF84003E9, 64'h0,  0);   // 3
    add(0, 64'h0, 0,  1, 64'h4,  32'hF84083EA, 64'h4,  0);   // 4 second word
    for (int i = 0; i < 5; i++)                               // 5..9 stall
      add(0, 64'h0, 0, 1, 64'h4, 32'hF84083EA, 64'h4, 0);
    add(0, 64'h0, 1,  0, 64'h8,  32'hF84083EA, 64'h4,  0);   // 10 accept
    add(0, 64'h0, 0,  0, 64'h8,  32'hF84083EA, 64'h4,  0);   // 11
    add(0, 64'h0, 0,  1, 64'h8,  32'hD0000008, 64'h8,  0);   // 12
    add(1, 64'h28, 0, 0, 64'h28, 32'hD0000008, 64'h8,  0);   // 13 redirect in VALID
    add(0, 64'h0, 0,  0, 64'h28, 32'hD0000008, 64'h8,  0);   // 14
    add(1, 64'h1C, 0, 0, 64'h1C, 32'hD0000008, 64'h8,  0);   // 15 abandon 0x28
    add(0, 64'h0, 0,  0, 64'h1C, 32'hD0000008, 64'h8,  0);   // 16
    add(0, 64'h0, 0,  1, 64'h1C, 32'hB5000123, 64'h1C, 0);   // 17
    add(1, 64'h28, 1, 0, 64'h28, 32'hB5000123, 64'h1C, 0);   // 18
    add(0, 64'h0, 0,  0, 64'h28, 32'hB5000123, 64'h1C, 0);   // 19
    add(0, 64'h0, 0,  1, 64'h28, 32'hD0000028, 64'h28, 0);   // 20
    add(1, 64'h1C, 1, 0, 64'h1C, 32'hD0000028, 64'h28, 0);   // 21 redirect+accept
    add(0, 64'h0, 0,  0, 64'h1C, 32'hD0000028, 64'h28, 0);   // 22
    add(0, 64'h0, 0,  1, 64'h1C, 32'hB5000123, 64'h1C, 0);   // 23 not 0x2C
    add(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hB5000123, 64'h1C, 0);
    add(0, 64'h0, 1,  0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hB5000123, 64'h1C, 0);
    add(0, 64'h0, 1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hDFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    add(0, 64'h0, 1,  0, 64'h0,  32'hDFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0); // wrap
    add(0, 64'h0, 1,  0, 64'h0,  32'hDFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    add(0, 64'h0, 0,  1, 64'h0,  32'hF84003E9, 64'h0,  0);   // 29
`ifdef FETCH_ALIGN_CHECK_EN
    add(1, 64'h1E, 0, 0, 64'h1E, 32'hF84003E9, 64'h0,  1);   // 30 halt
    add(0, 64'h0, 0,  0, 64'h1E, 32'hF84003E9, 64'h0,  1);
    add(0, 64'h0, 0,  0, 64'h1E, 32'hF84003E9, 64'h0,  1);
    add(1, 64'h0, 1,  0, 64'h1E, 32'hF84003E9, 64'h0,  1);   // redirect ignored
    add(0, 64'h0, 1,  0, 64'h1E, 32'hF84003E9, 64'h0,  1);
    add(0, 64'h0, 1,  0, 64'h1E, 32'hF84003E9, 64'h0,  1);
`else
    add(1, 64'h1E, 0, 0, 64'h1C, 32'hF84003E9, 64'h0,  0);   // 30 aligned down
    add(0, 64'h0, 0,  0, 64'h1C, 32'hF84003E9, 64'h0,  0);
    add(0, 64'h0, 0,  1, 64'h1C, 32'hB5000123, 64'h1C, 0);
    add(1, 64'h0, 1,  0, 64'h0,  32'hB5000123, 64'h1C, 0);
    add(0, 64'h0, 1,  0, 64'h0,  32'hB5000123, 64'h1C, 0);
    add(0, 64'h0, 1,  1, 64'h0,  32'hF84003E9, 64'h0,  0);
`endif

    Reset          = 1'b1;
    bus.InstrReady = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_outputs("reset", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      bus.Redirect   = vecs[i].redir;
      bus.RedirectPC = vecs[i].rpc;
      bus.InstrReady = vecs[i].ready;
      @(posedge CLK);
      #1;
      $display("vec %0d: redir=%0b rpc=%h ready=%0b -> valid=%0b addr=%h instr=%h pc=%h err=%0b",
               i, vecs[i].redir, vecs[i].rpc, vecs[i].ready, bus.InstrValid,
               bus.InstrAddr, bus.Instr, bus.InstrPC, bus.AlignErr);
      chk_outputs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].addr,
                  vecs[i].instr, vecs[i].pc, vecs[i].err);
    end
    bus.Redirect   = 1'b0;
    bus.InstrReady = 1'b0;

    // Asynchronous reset between clock edges (also clears HALT)
    #2 Reset = 1'b1;
    #1;
    $display("async reset mid-cycle: valid=%0b addr=%h err=%0b", bus.InstrValid, bus.InstrAddr, bus.AlignErr);
    chk_outputs("async_reset1", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0);
    @(posedge CLK);
    #1 Reset = 1'b0;

    // Redirect to 0x40: address next cycle, valid RD_CYCLES edges later
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 64'h40;
    @(posedge CLK);
    #1 bus.Redirect = 1'b0;
    chk("redir40 InstrAddr", bus.InstrAddr, 64'h40);
    cyc = 0;
    while (!bus.InstrValid && cyc < 10) begin
      @(posedge CLK);
      #1 cyc++;
    end
    $display("redirect 0x40: valid after %0d cycles instr=%h pc=%h", cyc, bus.Instr, bus.InstrPC);
    chk("redir40 latency", 64'(cyc), 64'd2);
    chk("redir40 Instr", 64'(bus.Instr), 64'hD0000040);
    chk("redir40 InstrPC", bus.InstrPC, 64'h40);

    // Reset while InstrValid is high drops the instruction immediately
    #2 Reset = 1'b1;
    #1;
    $display("async reset in VALID: valid=%0b addr=%h", bus.InstrValid, bus.InstrAddr);
    chk_outputs("async_reset2", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0);
    @(posedge CLK);
    #1 Reset = 1'b0;
    bus.InstrReady = 1'b1;
    cyc = 0;
    while (!bus.InstrValid && cyc < 10) begin
      @(posedge CLK);
      #1 cyc++;
    end
    $display("after reset: valid after %0d cycles instr=%h pc=%h", cyc, bus.Instr, bus.InstrPC);
    chk("reset latency", 64'(cyc), 64'd2);
    chk("reset first Instr", 64'(bus.Instr), 64'hF84003E9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
